// File: rtl/extest_wrapper_pkg.sv
// Shared constants and sequencer state type for the EXTEST boundary wrapper.
package extest_wrapper_pkg;

  localparam int WBR_LEN = 8;
  localparam int NUM_IN  = 4;
  localparam int NUM_OUT = 4;
  localparam int CNT_W   = 4;
  localparam logic [CNT_W-1:0] UPDATE_CNT = 4'd8;

  typedef enum logic {
    SHIFT  = 1'b0,
    UPDATE = 1'b1
  } seq_state_t;

  // Counts 0..7 shift the chain; the terminal count is the update/capture slot.
  function automatic seq_state_t seq_state(input logic [CNT_W-1:0] cnt);
    return (cnt == UPDATE_CNT) ? UPDATE : SHIFT;
  endfunction

endpackage

// File: rtl/wbc_cell.sv
// One wrapper boundary cell: shift flop with capture, plus an update flop
// that drives the functional output in EXTEST when HAS_UPDATE is set.
module wbc_cell #(
  parameter bit HAS_UPDATE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic si,
  input  logic cdata,
  input  logic shift,
  input  logic capture,
  input  logic update,
  input  logic mode,
  input  logic fin,
  output logic so,
  output logic fout
);

  logic shift_reg;
  logic upd_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= 1'b0;
    end else if (en) begin
      if (shift) begin
        shift_reg <= si;
      end else if (capture) begin
        shift_reg <= cdata;
      end
    end
  end

  // Without an update stage this flop never loads and folds away to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_reg <= 1'b0;
    end else if (en && update && HAS_UPDATE) begin
      upd_reg <= shift_reg;
    end
  end

  assign so   = shift_reg;
  assign fout = (mode && HAS_UPDATE) ? upd_reg : fin;

endmodule

// File: rtl/extest_wrapper.sv
// Accumulator core wrapped by an 8-cell boundary register with an EXTEST
// shift/update sequencer. Define EXTEST_CORE_HOLD_EN to freeze the core in EXTEST.
module extest_wrapper
  import extest_wrapper_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         extest_mode,
  input  logic         extest_scan_in,
  output logic         extest_scan_out,
  input  logic [3:0]   in,
  output logic [3:0]   out
);

  logic [3:0]       acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  seq_state_t       state;
  logic             shift_en;
  logic             upd_en;
  logic             core_en;
  logic [WBR_LEN:0] chain;
  logic [NUM_IN-1:0] core_in;

`ifdef EXTEST_CORE_HOLD_EN
  assign core_en = !extest_mode;
`else
  assign core_en = 1'b1;
`endif

  assign state = seq_state(cnt_reg);

  always_comb begin
    cnt_next = cnt_reg;
    shift_en = 1'b0;
    upd_en   = 1'b0;
    if (extest_mode) begin
      case (state)
        SHIFT: begin
          shift_en = 1'b1;
          cnt_next = cnt_reg + 4'd1;
        end
        UPDATE: begin
          upd_en   = 1'b1;
          cnt_next = '0;
        end
        default: cnt_next = '0;
      endcase
    end else begin
      // Leaving EXTEST forces a full 8-shift sequence on re-entry.
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_next;
    end
  end

  always_comb begin
    acc_next = acc_reg;
    if (core_en) begin
      acc_next = acc_reg + core_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_next;
    end
  end

  assign chain[0]        = extest_scan_in;
  assign extest_scan_out = chain[WBR_LEN];

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_iwbc
      wbc_cell #(.HAS_UPDATE(1'b0)) u_iwbc (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .si      (chain[gi]),
        .cdata   (in[gi]),
        .shift   (shift_en),
        .capture (upd_en),
        .update  (1'b0),
        .mode    (extest_mode),
        .fin     (in[gi]),
        .so      (chain[gi+1]),
        .fout    (core_in[gi])
      );
    end

    // Output cells hold their shift flops during the update slot.
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_owbc
      wbc_cell #(.HAS_UPDATE(1'b1)) u_owbc (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .si      (chain[NUM_IN+gi]),
        .cdata   (acc_reg[gi]),
        .shift   (shift_en),
        .capture (1'b0),
        .update  (upd_en),
        .mode    (extest_mode),
        .fin     (acc_reg[gi]),
        .so      (chain[NUM_IN+gi+1]),
        .fout    (out[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_extest_wrapper.sv
// Scoreboard bench for extest_wrapper: expectations are queued as stimulus is
// driven and checked one cycle later, after the clock edge.
module tb_extest_wrapper;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       extest_mode = 1'b0;
  logic       extest_scan_in = 1'b0;
  logic       extest_scan_out;
  logic [3:0] in_bus = 4'h0;
  logic [3:0] out_bus;

  typedef struct {
    string      tag;
    bit         is_scan;
    logic [3:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] acc_m = 4'h0;

  logic [0:7] shin_bits  = 8'b1011_0000;
  logic [0:7] shout_bits = 8'b1011_0110;
  logic [0:7] s_bits     = 8'b0110_1001;
  logic [0:7] p_bits     = 8'b1001_0000;
  logic [0:7] r_bits     = 8'b1100_0000;

  extest_wrapper dut (
    .clk             (clk),
    .reset           (reset),
    .en              (en),
    .extest_mode     (extest_mode),
    .extest_scan_in  (extest_scan_in),
    .extest_scan_out (extest_scan_out),
    .in              (in_bus),
    .out             (out_bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic push_out(input string tag, input logic [3:0] v);
    exp_t e;
    e.tag = tag; e.is_scan = 1'b0; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic push_scan(input string tag, input logic v);
    exp_t e;
    e.tag = tag; e.is_scan = 1'b1; e.val = {3'b000, v};
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.is_scan) check_val(e.tag, {3'b000, extest_scan_out}, e.val);
      else           check_val(e.tag, out_bus, e.val);
    end
  endtask

  function automatic bit core_runs(input logic m);
`ifdef EXTEST_CORE_HOLD_EN
    return !m;
`else
    return 1'b1;
`endif
  endfunction

  task automatic step(input logic e, input logic m, input logic [3:0] i, input logic s);
    en = e; extest_mode = m; in_bus = i; extest_scan_in = s;
    @(posedge clk);
    if (e && core_runs(m)) acc_m = acc_m + i;
    #1;
    drain();
  endtask

  task automatic apply_reset(input logic m);
    reset = 1'b1; en = 1'b1; extest_mode = m; in_bus = 4'h0; extest_scan_in = 1'b0;
    @(posedge clk);
    acc_m = 4'h0;
    #1;
    reset = 1'b0;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state in both modes
    push_out("rst_out_func", 4'h0);
    push_scan("rst_so_func", 1'b0);
    apply_reset(1'b0);
    extest_mode = 1'b1;
    #1;
    push_out("rst_out_extest", 4'h0);
    push_scan("rst_so_extest", 1'b0);
    drain();

    // Functional accumulation with wrap
    push_out("acc_3", 4'd3);  step(1'b1, 1'b0, 4'd3, 1'b1);
    push_out("acc_6", 4'd6);  step(1'b1, 1'b0, 4'd3, 1'b1);
    push_out("acc_9", 4'd9);  step(1'b1, 1'b0, 4'd3, 1'b1);
    push_out("acc_wrap", 4'd8);
    push_scan("func_chain_hold", 1'b0);
    step(1'b1, 1'b0, 4'd15, 1'b1);

    // Shift 1,0,1,1,0,0,0,0 then update with in=0110
    for (int i = 0; i < 8; i++) begin
      push_out($sformatf("shin_out_%0d", i), 4'h0);
      step(1'b1, 1'b1, 4'b0110, shin_bits[i]);
    end
    push_scan("first_bit_at_owbc3", 1'b1);
    drain();
    push_out("update_1011", 4'b1011);
    step(1'b1, 1'b1, 4'b0110, 1'b0);

    // Shift out captured/held pattern with a 3-cycle en=0 stall
    push_scan("shout_0", shout_bits[0]);
    drain();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        for (int h = 0; h < 3; h++) begin
          push_scan($sformatf("hold_so_%0d", h), shout_bits[3]);
          push_out($sformatf("hold_out_%0d", h), 4'b1011);
          step(1'b0, 1'b1, 4'hF, 1'b1);
        end
      end
      if (i < 7) push_scan($sformatf("shout_%0d", i + 1), shout_bits[i+1]);
      else       push_scan("shout_new_first", s_bits[0]);
      push_out($sformatf("shout_out_%0d", i), 4'b1011);
      step(1'b1, 1'b1, 4'b0110, s_bits[i]);
    end
    push_out("update_after_hold", 4'b0110);
    step(1'b1, 1'b1, 4'h0, 1'b0);

    // Drop EXTEST after 5 shifts, then re-enter: 8 full shifts needed
    for (int i = 0; i < 5; i++) begin
      push_out($sformatf("part_out_%0d", i), 4'b0110);
      step(1'b1, 1'b1, 4'h2, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      push_out($sformatf("func_gap_acc_%0d", i), acc_m + 4'h5);
      push_scan($sformatf("func_gap_so_%0d", i), 1'b0);
      step(1'b1, 1'b0, 4'h5, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      push_out($sformatf("reentry_out_%0d", i), 4'b0110);
      step(1'b1, 1'b1, 4'h1, p_bits[i]);
    end
    push_out("reentry_update", 4'b1001);
    step(1'b1, 1'b1, 4'h0, 1'b0);

    // Reset mid-shift aborts the sequence
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 4'h0, 1'b1);
    end
    push_out("midrst_out", 4'h0);
    push_scan("midrst_so", 1'b0);
    apply_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      push_out($sformatf("post_rst_out_%0d", i), 4'h0);
      step(1'b1, 1'b1, 4'h3, r_bits[i]);
    end
    push_out("post_rst_update", 4'b1100);
    step(1'b1, 1'b1, 4'h0, 1'b0);
    push_out("post_rst_func_acc", acc_m + 4'h7);
    step(1'b1, 1'b0, 4'h7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
